// File: rtl/dpram_generic.sv
// dpram_generic: two-port byte-writable RAM with a fixed-latency read pipeline,
// selectable read/write collision behaviour and out-of-range flagging.
module dpram_generic #(
    parameter string MemoryInitFile  = "none",
    parameter string MemoryPrimitive = "",
    parameter int    ReadLatency     = 1,
    parameter int    AddrBusWidth    = 32,
    parameter int    DataBusWidth    = 32,
    parameter int    MemSizeWords    = 0,
    parameter string CollisionMode   = "READ_FIRST"
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_re,
    input  logic                      a_we,
    input  logic [DataBusWidth/8-1:0] a_be,
    input  logic [AddrBusWidth-1:0]   a_addr,
    input  logic [DataBusWidth-1:0]   a_w_data,
    output logic [DataBusWidth-1:0]   a_r_data,
    output logic                      a_r_valid,
    output logic                      a_err,
    input  logic                      b_re,
    input  logic                      b_we,
    input  logic [DataBusWidth/8-1:0] b_be,
    input  logic [AddrBusWidth-1:0]   b_addr,
    input  logic [DataBusWidth-1:0]   b_w_data,
    output logic [DataBusWidth-1:0]   b_r_data,
    output logic                      b_r_valid,
    output logic                      b_err
);

    localparam int NumBytes = DataBusWidth / 8;
    localparam int IdxWidth = (MemSizeWords == 0) ? AddrBusWidth :
                              ((MemSizeWords > 1) ? $clog2(MemSizeWords) : 1);
    localparam longint unsigned MemWords = (MemSizeWords == 0) ? (64'd1 << AddrBusWidth) :
                                           longint'(MemSizeWords);
    localparam logic [AddrBusWidth:0] LimitVal = (AddrBusWidth + 1)'(MemWords);
    localparam bit WriteFirst = (CollisionMode == "WRITE_FIRST");

    if ((ReadLatency < 1) || (ReadLatency > 4)) begin : g_chk_latency
        $error("dpram_generic: ReadLatency %0d outside 1..4", ReadLatency);
    end
    if ((DataBusWidth % 8) != 0) begin : g_chk_width
        $error("dpram_generic: DataBusWidth %0d is not a multiple of 8", DataBusWidth);
    end
    if ((CollisionMode != "READ_FIRST") && (CollisionMode != "WRITE_FIRST")) begin : g_chk_mode
        $error("dpram_generic: CollisionMode must be READ_FIRST or WRITE_FIRST");
    end
    if ((MemSizeWords > 0) && ($clog2(MemSizeWords) > AddrBusWidth)) begin : g_chk_size
        $error("dpram_generic: MemSizeWords %0d not addressable", MemSizeWords);
    end

    logic                    re_s       [2];
    logic                    we_s       [2];
    logic [NumBytes-1:0]     be_s       [2];
    logic [AddrBusWidth-1:0] addr_s     [2];
    logic [DataBusWidth-1:0] wdata_s    [2];
    logic [IdxWidth-1:0]     idx_s      [2];
    logic                    in_range_s [2];
    logic                    wr_ok_s    [2];
    logic                    wr_oor_s   [2];
    logic [DataBusWidth-1:0] old_s      [2];
    logic [DataBusWidth-1:0] merged_s   [2];
    logic [DataBusWidth-1:0] rd_word_s  [2];
    logic                    valid_in_s [2][ReadLatency];
    logic [DataBusWidth-1:0] data_in_s  [2][ReadLatency];
    logic                    err_in_s   [2][ReadLatency];
    logic                    valid_r    [2][ReadLatency];
    logic [DataBusWidth-1:0] data_r     [2][ReadLatency];
    logic                    err_r      [2][ReadLatency];

    (* ram_style = MemoryPrimitive *)
    logic [DataBusWidth-1:0] mem_r [0:MemWords-1];

    assign re_s[0]    = a_re;
    assign re_s[1]    = b_re;
    assign we_s[0]    = a_we;
    assign we_s[1]    = b_we;
    assign be_s[0]    = a_be;
    assign be_s[1]    = b_be;
    assign addr_s[0]  = a_addr;
    assign addr_s[1]  = b_addr;
    assign wdata_s[0] = a_w_data;
    assign wdata_s[1] = b_w_data;

    // Address decode, range check and write qualification per port
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            idx_s[p]      = addr_s[p][IdxWidth-1:0];
            in_range_s[p] = ({1'b0, addr_s[p]} < LimitVal);
            wr_ok_s[p]    = rst & we_s[p] & in_range_s[p];
            wr_oor_s[p]   = we_s[p] & ~in_range_s[p];
        end
    end

    // Read word per port; the merged view applies this cycle's writes with port a on top
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            old_s[p]    = mem_r[idx_s[p]];
            merged_s[p] = old_s[p];
            for (int i = 0; i < NumBytes; i++) begin
                merged_s[p][8*i +: 8] =
                    (wr_ok_s[0] && (addr_s[0] == addr_s[p]) && be_s[0][i]) ? wdata_s[0][8*i +: 8] :
                    (wr_ok_s[1] && (addr_s[1] == addr_s[p]) && be_s[1][i]) ? wdata_s[1][8*i +: 8] :
                    old_s[p][8*i +: 8];
            end
            rd_word_s[p] = (!in_range_s[p]) ? {DataBusWidth{1'b0}} :
                           (WriteFirst ? merged_s[p] : old_s[p]);
        end
    end

    // Inputs of each pipeline stage: stage 0 takes the request, later stages the previous stage
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            valid_in_s[p][0] = re_s[p];
            data_in_s[p][0]  = rd_word_s[p];
            err_in_s[p][0]   = re_s[p] & ~in_range_s[p];
            for (int k = 1; k < ReadLatency; k++) begin
                valid_in_s[p][k] = valid_r[p][k-1];
                data_in_s[p][k]  = data_r[p][k-1];
                err_in_s[p][k]   = err_r[p][k-1];
            end
        end
    end

    // Read pipeline; data stages load only behind a valid so the last stage holds its value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < ReadLatency; k++) begin
                    valid_r[p][k] <= 1'b0;
                    data_r[p][k]  <= {DataBusWidth{1'b0}};
                    err_r[p][k]   <= 1'b0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < ReadLatency; k++) begin
                    valid_r[p][k] <= valid_in_s[p][k];
                    err_r[p][k]   <= err_in_s[p][k] | ((k == (ReadLatency - 1)) && wr_oor_s[p]);
                    if (valid_in_s[p][k]) begin
                        data_r[p][k] <= data_in_s[p][k];
                    end
                end
            end
        end
    end

    // Byte-masked writes; port a is applied last so it wins bytes both ports enable
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumBytes; i++) begin
            if (wr_ok_s[1] && be_s[1][i]) begin
                mem_r[idx_s[1]][8*i +: 8] <= wdata_s[1][8*i +: 8];
            end
            if (wr_ok_s[0] && be_s[0][i]) begin
                mem_r[idx_s[0]][8*i +: 8] <= wdata_s[0][8*i +: 8];
            end
        end
    end

    assign a_r_data  = data_r[0][ReadLatency-1];
    assign a_r_valid = valid_r[0][ReadLatency-1];
    assign a_err     = err_r[0][ReadLatency-1];
    assign b_r_data  = data_r[1][ReadLatency-1];
    assign b_r_valid = valid_r[1][ReadLatency-1];
    assign b_err     = err_r[1][ReadLatency-1];

endmodule

// File: tb/tb_dpram_generic.sv
// Bench for dpram_generic: a READ_FIRST and a WRITE_FIRST instance share stimulus and are
// compared every cycle against a word-level memory model with a due-cycle schedule.
module tb_dpram_generic;

    localparam int RL    = 3;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int WORDS = 16;
    localparam int NCYC  = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_re, a_we, b_re, b_we;
    logic [3:0]    a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_w_data, b_w_data;
    logic [DW-1:0] rf_a_r_data, rf_b_r_data, wf_a_r_data, wf_b_r_data;
    logic          rf_a_r_valid, rf_b_r_valid, wf_a_r_valid, wf_b_r_valid;
    logic          rf_a_err, rf_b_err, wf_a_err, wf_b_err;

    logic [DW-1:0] model_mem [WORDS];
    bit            exp_v    [2][NCYC];
    bit            exp_e    [2][NCYC];
    logic [DW-1:0] exp_d_rf [2][NCYC];
    logic [DW-1:0] exp_d_wf [2][NCYC];
    logic [DW-1:0] hold_rf  [2];
    logic [DW-1:0] hold_wf  [2];
    int            cyc;
    int            checks;
    int            errors;
    int            seen;

    always #5 clk = ~clk;

    dpram_generic #(
        .ReadLatency(RL), .AddrBusWidth(AW), .DataBusWidth(DW),
        .MemSizeWords(WORDS), .CollisionMode("READ_FIRST")
    ) u_rf (
        .clk(clk), .rst(rst),
        .a_re(a_re), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_w_data(a_w_data),
        .a_r_data(rf_a_r_data), .a_r_valid(rf_a_r_valid), .a_err(rf_a_err),
        .b_re(b_re), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_w_data(b_w_data),
        .b_r_data(rf_b_r_data), .b_r_valid(rf_b_r_valid), .b_err(rf_b_err)
    );

    dpram_generic #(
        .ReadLatency(RL), .AddrBusWidth(AW), .DataBusWidth(DW),
        .MemSizeWords(WORDS), .CollisionMode("WRITE_FIRST")
    ) u_wf (
        .clk(clk), .rst(rst),
        .a_re(a_re), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_w_data(a_w_data),
        .a_r_data(wf_a_r_data), .a_r_valid(wf_a_r_valid), .a_err(wf_a_err),
        .b_re(b_re), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_w_data(b_w_data),
        .b_r_data(wf_b_r_data), .b_r_valid(wf_b_r_valid), .b_err(wf_b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old, input logic [3:0] be,
                                                 input logic [DW-1:0] data);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    task automatic drive(input int p, input bit re, input bit we, input logic [3:0] be,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        if (p == 0) begin
            a_re = re; a_we = we; a_be = be; a_addr = ad; a_w_data = wd;
        end else begin
            b_re = re; b_we = we; b_be = be; b_addr = ad; b_w_data = wd;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 4'h0, 8'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 4'h0, 8'd0, 32'd0);
    endtask

    // Apply the currently driven requests to the model at edge n
    task automatic model_edge(input int n);
        bit            re [2];
        bit            we [2];
        logic [3:0]    be [2];
        int            ad [2];
        logic [DW-1:0] wd [2];
        logic [DW-1:0] snap [WORDS];
        re[0] = a_re; we[0] = a_we; be[0] = a_be; ad[0] = int'(a_addr); wd[0] = a_w_data;
        re[1] = b_re; we[1] = b_we; be[1] = b_be; ad[1] = int'(b_addr); wd[1] = b_w_data;
        snap = model_mem;
        for (int p = 1; p >= 0; p--) begin
            if (we[p] && ad[p] < WORDS) model_mem[ad[p]] = byte_merge(model_mem[ad[p]], be[p], wd[p]);
        end
        for (int p = 0; p < 2; p++) begin
            if (re[p]) begin
                exp_v[p][n+RL-1] = 1'b1;
                if (ad[p] < WORDS) begin
                    exp_d_rf[p][n+RL-1] = snap[ad[p]];
                    exp_d_wf[p][n+RL-1] = model_mem[ad[p]];
                end else begin
                    exp_d_rf[p][n+RL-1] = 32'd0;
                    exp_d_wf[p][n+RL-1] = 32'd0;
                    exp_e[p][n+RL-1]    = 1'b1;
                end
            end
            if (we[p] && ad[p] >= WORDS) exp_e[p][n] = 1'b1;
        end
    endtask

    task automatic cycle();
        int n;
        n = cyc;
        if (rst) begin
            model_edge(n);
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int k = n; k <= n + RL; k++) begin
                    exp_v[p][k] = 1'b0;
                    exp_e[p][k] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (!rst) begin
                hold_rf[p] = 32'd0;
                hold_wf[p] = 32'd0;
            end else if (exp_v[p][n]) begin
                hold_rf[p] = exp_d_rf[p][n];
                hold_wf[p] = exp_d_wf[p][n];
            end
        end
        chk("rf_a_valid", rf_a_r_valid, exp_v[0][n]);
        chk("rf_b_valid", rf_b_r_valid, exp_v[1][n]);
        chk("wf_a_valid", wf_a_r_valid, exp_v[0][n]);
        chk("wf_b_valid", wf_b_r_valid, exp_v[1][n]);
        chk("rf_a_err", rf_a_err, exp_e[0][n]);
        chk("rf_b_err", rf_b_err, exp_e[1][n]);
        chk("wf_a_err", wf_a_err, exp_e[0][n]);
        chk("wf_b_err", wf_b_err, exp_e[1][n]);
        chk("rf_a_data", rf_a_r_data, hold_rf[0]);
        chk("rf_b_data", rf_b_r_data, hold_rf[1]);
        chk("wf_a_data", wf_a_r_data, hold_wf[0]);
        chk("wf_b_data", wf_b_r_data, hold_wf[1]);
        cyc++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        seen   = 0;
        hold_rf[0] = 32'd0; hold_rf[1] = 32'd0;
        hold_wf[0] = 32'd0; hold_wf[1] = 32'd0;
        rst = 1'b0;
        idle();
        #1;
        chk("reset_rf_a_valid", rf_a_r_valid, 1'b0);
        chk("reset_rf_a_data", rf_a_r_data, 32'd0);
        chk("reset_wf_b_err", wf_b_err, 1'b0);
        repeat (3) cycle();

        // Fill every word so later reads have defined expectations
        rst = 1'b1;
        for (int w = 0; w < WORDS; w += 2) begin
            drive(0, 1'b0, 1'b1, 4'hF, 8'(w), $urandom);
            drive(1, 1'b0, 1'b1, 4'hF, 8'(w + 1), $urandom);
            cycle();
        end

        // Latency 3: write then read word 5
        idle(); drive(0, 1'b0, 1'b1, 4'hF, 8'd5, 32'hDEADBEEF); cycle();
        idle(); drive(0, 1'b1, 1'b0, 4'h0, 8'd5, 32'd0); cycle();
        chk("lat_t0_valid", rf_a_r_valid, 1'b0);
        idle(); cycle();
        chk("lat_t1_valid", rf_a_r_valid, 1'b0);
        cycle();
        chk("lat_t2_valid", rf_a_r_valid, 1'b1);
        chk("lat_t2_data", rf_a_r_data, 32'hDEADBEEF);
        cycle();
        chk("lat_t3_valid", rf_a_r_valid, 1'b0);
        chk("lat_t3_hold", rf_a_r_data, 32'hDEADBEEF);

        // Byte-enable merge on word 7
        idle(); drive(0, 1'b0, 1'b1, 4'hF, 8'd7, 32'h11223344); cycle();
        idle(); drive(0, 1'b0, 1'b1, 4'b0101, 8'd7, 32'hAABBCCDD); cycle();
        idle(); drive(0, 1'b1, 1'b0, 4'h0, 8'd7, 32'd0); cycle();
        idle(); cycle(); cycle();
        chk("be_merge", rf_a_r_data, 32'h11BB33DD);

        // Cross-port collision on word 9
        idle(); drive(0, 1'b0, 1'b1, 4'hF, 8'd9, 32'd0); cycle();
        idle(); drive(0, 1'b0, 1'b1, 4'hF, 8'd9, 32'hFFFFFFFF);
        drive(1, 1'b1, 1'b0, 4'h0, 8'd9, 32'd0); cycle();
        idle(); cycle(); cycle();
        chk("coll_read_first", rf_b_r_data, 32'd0);
        chk("coll_write_first", wf_b_r_data, 32'hFFFFFFFF);

        // Dual write to word 2
        idle(); drive(0, 1'b0, 1'b1, 4'hF, 8'd2, 32'd0); cycle();
        idle(); drive(0, 1'b0, 1'b1, 4'b0011, 8'd2, 32'h0000AAAA);
        drive(1, 1'b0, 1'b1, 4'b0110, 8'd2, 32'h00BBBB00); cycle();
        idle(); drive(0, 1'b1, 1'b0, 4'h0, 8'd2, 32'd0); cycle();
        idle(); cycle(); cycle();
        chk("dual_write", rf_a_r_data, 32'h00BBAAAA);

        // Out-of-range read and write at address 20
        idle(); drive(0, 1'b1, 1'b0, 4'h0, 8'd20, 32'd0); cycle();
        idle(); cycle(); cycle();
        chk("oor_rd_valid", rf_a_r_valid, 1'b1);
        chk("oor_rd_data", rf_a_r_data, 32'd0);
        chk("oor_rd_err", rf_a_err, 1'b1);
        idle(); drive(0, 1'b0, 1'b1, 4'hF, 8'd20, 32'h12345678); cycle();
        chk("oor_wr_err", rf_a_err, 1'b1);
        idle(); drive(0, 1'b1, 1'b0, 4'h0, 8'd4, 32'd0); cycle();
        chk("oor_wr_err_end", rf_a_err, 1'b0);
        idle(); cycle(); cycle();

        // Reset with reads in flight, plus a read during reset
        idle(); drive(0, 1'b1, 1'b0, 4'h0, 8'd3, 32'd0); cycle();
        drive(0, 1'b1, 1'b0, 4'h0, 8'd4, 32'd0); cycle();
        rst = 1'b0; drive(0, 1'b1, 1'b0, 4'h0, 8'd5, 32'd0); cycle();
        chk("rst_data", rf_a_r_data, 32'd0);
        rst = 1'b1; idle(); drive(0, 1'b1, 1'b0, 4'h0, 8'd6, 32'd0); cycle();
        seen += int'(rf_a_r_valid);
        idle(); cycle();
        seen += int'(rf_a_r_valid);
        chk("rst_flush", 32'(seen), 32'd0);
        cycle();
        chk("post_rst_valid", rf_a_r_valid, 1'b1);
        chk("post_rst_data", rf_a_r_data, model_mem[6]);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                logic [AW-1:0] ad;
                if ($urandom_range(0, 7) == 0) ad = 8'($urandom_range(16, 255));
                else if ($urandom_range(0, 1) == 0) ad = 8'($urandom_range(0, 3));
                else ad = 8'($urandom_range(0, 15));
                drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), ad, $urandom);
            end
            rst = ($urandom_range(0, 63) != 0);
            cycle();
        end

        idle();
        rst = 1'b1;
        repeat (RL + 1) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
